// File: rtl/seq_cla_sub.sv
// rtl/seq_cla_sub.sv - multi-cycle subtractor, one 8-bit carry-lookahead slice per clock
// WIDTH must be a multiple of 8 and at least 8.

module seq_cla_sub_slice (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       c_acc;
  logic       p_acc;

  // Each carry is expanded as a flat generate/propagate product so no carry ripples through the slice.
  always_comb begin
    g     = a_i & ~b_i;
    p     = a_i ^ ~b_i;
    c     = '0;
    c_acc = 1'b0;
    p_acc = 1'b0;
    c[0]  = cin_i;
    for (int i = 0; i < 8; i++) begin
      c_acc = g[i];
      p_acc = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_acc = c_acc | (p_acc & g[j]);
        p_acc = p_acc & p[j];
      end
      c[i+1] = c_acc | (p_acc & cin_i);
    end
    sum_o  = p ^ c[7:0];
    cout_o = c[8];
  end

endmodule

module seq_cla_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf
);

  localparam int NS = WIDTH / 8;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       slice_a;
  logic [7:0]       slice_b;
  logic [7:0]       slice_sum;
  logic             slice_cout;

  // Constant-index select/merge keeps every part-select in range for any NS.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    d_d     = d_q;
    for (int s = 0; s < NS; s++) begin
      if (idx_q == IW'(s)) begin
        slice_a          = a_q[8*s +: 8];
        slice_b          = b_q[8*s +: 8];
        d_d[8*s +: 8]    = slice_sum;
      end
    end
  end

  seq_cla_sub_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            d_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b1;
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          d_q     <= d_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            borrow_q <= ~slice_cout;
            ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_sum[7] != a_q[WIDTH-1]);
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign d      = d_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_cla_sub.sv
// tb/tb_seq_cla_sub.sv - self-checking bench for seq_cla_sub (WIDTH 32 and WIDTH 8)

module tb_seq_cla_sub;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        borrow;
  logic        ovf;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  d8;
  logic        borrow8;
  logic        ovf8;

  int tests;
  int fails;

  seq_cla_sub #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .borrow(borrow), .ovf(ovf)
  );

  seq_cla_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .borrow(borrow8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        borrow;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic model(input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] ed, output logic eb, output logic eo);
    longint diff;
    ed   = av - bv;
    eb   = (av < bv);
    diff = longint'($signed(av)) - longint'($signed(bv));
    eo   = (diff > 64'sd2147483647) || (diff < -64'sd2147483648);
  endtask

  // Called right after an accepting edge (+1); returns edges until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!done && busy !== 1'b1) chk("busy_during_run", busy, 1'b1);
    end
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] ed, input logic eb, input logic eo);
    int lat;
    logic [31:0] held;
    issue(av, bv);
    chk({tag, "_busy_after_accept"}, busy, 1'b1);
    wait_done(lat);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_d"}, d, ed);
    chk({tag, "_borrow"}, borrow, eb);
    chk({tag, "_ovf"}, ovf, eo);
    held = d;
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, done, 1'b0);
    chk({tag, "_d_held"}, d, ed);
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    logic [31:0] av, bv, ed;
    logic eb, eo;
    logic [7:0] e8;

    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;

    vecs[0] = '{32'd5,        32'd3,        32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'd3,        32'd5,        32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[2] = '{32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1};
    vecs[5] = '{32'd9,        32'd9,        32'h00000000, 1'b0, 1'b0};
    vecs[6] = '{32'd0,        32'd0,        32'h00000000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_d", d, 32'h0);
    chk("reset_borrow", borrow, 1'b0);
    chk("reset_ovf", ovf, 1'b0);

    for (int i = 0; i < 7; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].borrow, vecs[i].ovf);

    // start during RUN is ignored
    issue(32'd10, 32'd4);
    @(posedge clk); #1;
    start = 1'b1; a = '0; b = '0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("ignore_start_latency", lat, 4);
    chk("ignore_start_d", d, 32'd6);

    // start held in the DONE cycle is accepted back-to-back
    start = 1'b1; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_drops", done, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    wait_done(lat);
    chk("b2b_latency", lat, 4);
    chk("b2b_d", d, 32'hFFFFFFFF);
    chk("b2b_borrow", borrow, 1'b1);

    // reset mid-RUN after slice 1, with borrow/ovf previously set
    run_check("pre_rst", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);
    issue(32'h12345678, 32'h00000001);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_done", done, 1'b0);
    chk("midrun_rst_d", d, 32'h0);
    chk("midrun_rst_borrow", borrow, 1'b0);
    chk("midrun_rst_ovf", ovf, 1'b0);
    run_check("post_rst", 32'd9, 32'd9, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      av = $urandom;
      bv = (i % 5 == 0) ? av : $urandom;
      if (i % 7 == 3) bv = {~av[31], bv[30:0]};
      model(av, bv, ed, eb, eo);
      run_check($sformatf("rand%0d", i), av, bv, ed, eb, eo);
    end

    // WIDTH=8: RUN is a single edge
    for (int i = 0; i < 20; i++) begin
      av = {24'h0, 8'($urandom)};
      bv = {24'h0, 8'($urandom)};
      if (i == 0) begin av = 32'h80; bv = 32'h01; end
      if (i == 1) begin av = 32'h7F; bv = 32'hFF; end
      e8 = av[7:0] - bv[7:0];
      @(negedge clk);
      start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0];
      @(posedge clk); #1;
      start8 = 1'b0;
      chk($sformatf("w8_busy%0d", i), busy8, 1'b1);
      @(posedge clk); #1;
      chk($sformatf("w8_done%0d", i), done8, 1'b1);
      chk($sformatf("w8_d%0d", i), d8, e8);
      chk($sformatf("w8_borrow%0d", i), borrow8, (av[7:0] < bv[7:0]));
      chk($sformatf("w8_ovf%0d", i), ovf8,
          ((int'($signed(av[7:0])) - int'($signed(bv[7:0]))) > 127) ||
          ((int'($signed(av[7:0])) - int'($signed(bv[7:0]))) < -128));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
